// File: rtl/maxpool_controller_pkg.sv
// Shared types for the max-pooling controller: FSM states, default data width.
// `ADDR_SZ (address width) defaults here unless the build predefines it.
`ifndef ADDR_SZ
`define ADDR_SZ 20
`endif

package maxpool_controller_pkg;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  // counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/maxpool_controller_if.sv
// Feature-map RAM bus seen by the pooling controller: read port and write port.
interface maxpool_controller_if #(parameter int DATA_W = 16);
  logic [`ADDR_SZ-1:0] src_addr;
  logic [DATA_W-1:0]   rd_data;
  logic [`ADDR_SZ-1:0] des_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_en;

  modport master (output src_addr, des_addr, wr_data, wr_en, input rd_data);
  modport slave  (input src_addr, des_addr, wr_data, wr_en, output rd_data);
endinterface

// File: rtl/maxpool_addr_gen.sv
// Window walker: nested c/r/k/dy/dx counters, source/destination address
// arithmetic and first/last-of-window flags for the current read.
module maxpool_addr_gen
  import maxpool_controller_pkg::*;
#(
  parameter int WIDTH_SRC  = 24,
  parameter int HEIGHT_SRC = 24,
  parameter int DEPTH_SRC  = 128,
  parameter int STRIDE     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_adv,
  output logic [`ADDR_SZ-1:0] o_src_addr,
  output logic [`ADDR_SZ-1:0] o_des_addr,
  output logic                o_first,
  output logic                o_last,
  output logic                o_end
);
  localparam int OW = WIDTH_SRC / STRIDE;
  localparam int OH = HEIGHT_SRC / STRIDE;
  localparam int SW = cnt_w(STRIDE);
  localparam int KW = cnt_w(OW);
  localparam int RW = cnt_w(OH);
  localparam int CW = cnt_w(DEPTH_SRC);
  localparam int AW = `ADDR_SZ;

  logic [SW-1:0] r_dx, r_dy;
  logic [KW-1:0] r_k;
  logic [RW-1:0] r_r;
  logic [CW-1:0] r_c;
  logic w_dx_max, w_dy_max, w_k_max, w_r_max, w_c_max;
  logic [AW-1:0] w_x, w_y;

  assign w_dx_max = (r_dx == SW'(STRIDE - 1));
  assign w_dy_max = (r_dy == SW'(STRIDE - 1));
  assign w_k_max  = (r_k  == KW'(OW - 1));
  assign w_r_max  = (r_r  == RW'(OH - 1));
  assign w_c_max  = (r_c  == CW'(DEPTH_SRC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dx <= '0; r_dy <= '0; r_k <= '0; r_r <= '0; r_c <= '0;
    end else if (i_adv) begin
      r_dx <= w_dx_max ? '0 : r_dx + SW'(1);
      if (w_dx_max) begin
        r_dy <= w_dy_max ? '0 : r_dy + SW'(1);
        if (w_dy_max) begin
          r_k <= w_k_max ? '0 : r_k + KW'(1);
          if (w_k_max) begin
            r_r <= w_r_max ? '0 : r_r + RW'(1);
            if (w_r_max) r_c <= w_c_max ? '0 : r_c + CW'(1);
          end
        end
      end
    end
  end

  // all arithmetic deliberately wraps at the address width
  assign w_x        = AW'(r_k) * AW'(STRIDE) + AW'(r_dx);
  assign w_y        = AW'(r_r) * AW'(STRIDE) + AW'(r_dy);
  assign o_src_addr = w_x + AW'(WIDTH_SRC) * (w_y + AW'(HEIGHT_SRC) * AW'(r_c));
  assign o_des_addr = AW'(r_k) + AW'(OW) * (AW'(r_r) + AW'(OH) * AW'(r_c));
  assign o_first    = (r_dx == '0) && (r_dy == '0);
  assign o_last     = w_dx_max && w_dy_max;
  assign o_end      = o_last && w_k_max && w_r_max && w_c_max;
endmodule

// File: rtl/maxpool_controller.sv
// STRIDE x STRIDE max-pooling controller: one read per enabled cycle, one write per window.
// Define MAXPOOL_RELU_EN to clamp negative pooled values to zero on the write path.
module maxpool_controller
  import maxpool_controller_pkg::*;
#(
  parameter int WIDTH_SRC  = 24,
  parameter int HEIGHT_SRC = 24,
  parameter int DEPTH_SRC  = 128,
  parameter int STRIDE     = 2,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic done,
  maxpool_controller_if.master bus
);
  typedef struct packed {
    logic                vld;
    logic                first;
    logic                last;
    logic [`ADDR_SZ-1:0] des;
  } tok_t;

  state_t                     r_state;
  tok_t [RD_LATENCY:0]        r_tok;
  logic [`ADDR_SZ-1:0]        r_src_addr, r_des_addr;
  logic signed [DATA_W-1:0]   r_acc, r_wr_data;
  logic                       r_wr_en, r_done;
  logic signed [DATA_W-1:0]   w_rd, w_max, w_res;
  logic [`ADDR_SZ-1:0]        w_src, w_des;
  logic                       w_issue, w_busy, w_first, w_last, w_end;
  tok_t                       w_arr;

  maxpool_addr_gen #(
    .WIDTH_SRC(WIDTH_SRC), .HEIGHT_SRC(HEIGHT_SRC),
    .DEPTH_SRC(DEPTH_SRC), .STRIDE(STRIDE)
  ) u_agen (
    .clk(clk), .rst_n(reset_n), .i_adv(w_issue),
    .o_src_addr(w_src), .o_des_addr(w_des),
    .o_first(w_first), .o_last(w_last), .o_end(w_end)
  );

  assign w_issue = enable && (r_state == S_IDLE || r_state == S_ISSUE);

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i <= RD_LATENCY; i++) w_busy |= r_tok[i].vld;
  end

  // token at the tail lines up with rd_data for its address
  assign w_arr = r_tok[RD_LATENCY];
  assign w_rd  = bus.rd_data;
  assign w_max = (w_arr.first || w_rd > r_acc) ? w_rd : r_acc;
`ifdef MAXPOOL_RELU_EN
  assign w_res = w_max[DATA_W-1] ? '0 : w_max;
`else
  assign w_res = w_max;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_tok      <= '0;
      r_src_addr <= '0;
      r_des_addr <= '0;
      r_acc      <= '0;
      r_wr_data  <= '0;
      r_wr_en    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tok[0] <= w_issue ? tok_t'{vld: 1'b1, first: w_first, last: w_last, des: w_des} : '0;
      for (int i = 1; i <= RD_LATENCY; i++) r_tok[i] <= r_tok[i-1];
      if (w_issue) r_src_addr <= w_src;
      if (w_arr.vld) r_acc <= w_max;
      r_wr_en <= w_arr.vld && w_arr.last;
      if (w_arr.vld && w_arr.last) begin
        r_wr_data  <= w_res;
        r_des_addr <= w_arr.des;
      end
      case (r_state)
        S_IDLE, S_ISSUE: if (w_issue) r_state <= w_end ? S_DRAIN : S_ISSUE;
        // pipe empties on the same edge the final write is registered
        S_DRAIN: if (!w_busy) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_DONE;
      endcase
    end
  end

  assign bus.src_addr = r_src_addr;
  assign bus.des_addr = r_des_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.wr_en    = r_wr_en;
  assign done         = r_done;
endmodule

// File: tb/tb_maxpool_controller.sv
// Randomized self-checking bench: two controllers (read latency 1 and 3) on a 4x4x2 map,
// checked against a window-by-window reference computed from the pooling rules.
module tb_maxpool_controller;
  import maxpool_controller_pkg::*;
  localparam int W = 4, H = 4, D = 2, S = 2, DW = 16;
  localparam int NWR = D * (H / S) * (W / S);
  localparam int NRD = D * H * W;

  logic clk = 1'b0, reset_n = 1'b0, en1 = 1'b0, en3 = 1'b0;
  logic done1, done3;
  logic sel = 1'b0;
  int   mode = 0;
  int   rnd [32];
  int   n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  maxpool_controller_if #(.DATA_W(DW)) if1 ();
  maxpool_controller_if #(.DATA_W(DW)) if3 ();

  maxpool_controller #(.WIDTH_SRC(W), .HEIGHT_SRC(H), .DEPTH_SRC(D), .STRIDE(S),
    .DATA_W(DW), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .enable(en1), .done(done1), .bus(if1.master));

  maxpool_controller #(.WIDTH_SRC(W), .HEIGHT_SRC(H), .DEPTH_SRC(D), .STRIDE(S),
    .DATA_W(DW), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .enable(en3), .done(done3), .bus(if3.master));

  function automatic logic [DW-1:0] memf(input int md, input logic [`ADDR_SZ-1:0] a);
    int v;
    v = int'(a);
    case (md)
      0:       return DW'(v);
      1:       return DW'(-(v + 1));
      2:       return DW'(v ^ 3);
      default: return DW'(rnd[v % 32]);
    endcase
  endfunction

  // memory: rd_data shows mem[addr] exactly RD_LATENCY cycles after addr appears
  logic [`ADDR_SZ-1:0]      aq1 = '0;
  logic [2:0][`ADDR_SZ-1:0] aq3 = '0;
  always_ff @(posedge clk) begin
    aq1 <= if1.src_addr;
    aq3 <= {aq3[1:0], if3.src_addr};
  end
  assign if1.rd_data = memf(mode, aq1);
  assign if3.rd_data = memf(mode, aq3[2]);

  logic [`ADDR_SZ-1:0] m_src, m_des;
  logic [DW-1:0]       m_wr;
  logic                m_wr_en, m_done;
  assign m_src   = sel ? if3.src_addr : if1.src_addr;
  assign m_des   = sel ? if3.des_addr : if1.des_addr;
  assign m_wr    = sel ? if3.wr_data  : if1.wr_data;
  assign m_wr_en = sel ? if3.wr_en    : if1.wr_en;
  assign m_done  = sel ? done3        : done1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_src"}, m_src, 0);
    chk({tag, "_des"}, m_des, 0);
    chk({tag, "_wdata"}, m_wr, 0);
    chk({tag, "_wr_en"}, m_wr_en, 0);
    chk({tag, "_done"}, m_done, 0);
  endtask

  task automatic do_reset(input logic s);
    sel = s; en1 = 1'b0; en3 = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); chk_zero("reset");
    reset_n = 1'b1;
  endtask

  // enm: 0 enable held high, 1 toggled every cycle, 2 random
  task automatic run(input logic s, input int md, input int enm);
    int ea[$], ed[$], es[$], gs[$];
    int last_s, t5, tw, lastwr, dcyc, nwr, mx, v, a, lat;
    logic en;
    sel = s; mode = md; lat = s ? 3 : 1;
    for (int c = 0; c < D; c++)
      for (int r = 0; r < H / S; r++)
        for (int k = 0; k < W / S; k++) begin
          mx = 0;
          for (int dy = 0; dy < S; dy++)
            for (int dx = 0; dx < S; dx++) begin
              a = (k * S + dx) + W * ((r * S + dy) + H * c);
              es.push_back(a);
              v = int'($signed(memf(md, `ADDR_SZ'(a))));
              if ((dy == 0 && dx == 0) || v > mx) mx = v;
            end
`ifdef MAXPOOL_RELU_EN
          if (mx < 0) mx = 0;
`endif
          ea.push_back(k + (W / S) * (r + (H / S) * c));
          ed.push_back(mx);
        end
    gs.push_back(0); last_s = 0;
    t5 = -1; tw = -1; lastwr = -1; dcyc = -1; nwr = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (int'(m_src) != last_s) begin last_s = int'(m_src); gs.push_back(last_s); end
      if (t5 < 0 && m_src == 5) t5 = cyc;
      if (m_wr_en) begin
        if (nwr < NWR) begin
          chk("wr_addr", m_des, ea[nwr]);
          chk("wr_data", $signed(m_wr), ed[nwr]);
        end
        if (tw < 0) tw = cyc;
        lastwr = cyc; nwr++;
      end
      if (m_done) begin dcyc = cyc; break; end
      en = (enm == 0) ? 1'b1 : (enm == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      if (s) en3 = en; else en1 = en;
    end
    en1 = 1'b0; en3 = 1'b0;
    chk("done_seen", dcyc >= 0, 1);
    chk("done_after_last_wr", dcyc - lastwr, 1);
    chk("n_writes", nwr, NWR);
    chk("n_reads", gs.size(), NRD);
    for (int i = 0; i < gs.size() && i < es.size(); i++) chk("src_seq", gs[i], es[i]);
    if (enm == 0) chk("wr_latency", tw - t5, lat + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [`ADDR_SZ-1:0] hold;
    do_reset(0);
    run(0, 0, 0);

    // after done: enable ignored
    hold = m_src; en1 = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("post_done_wr_en", m_wr_en, 0);
      chk("post_done_src", m_src, hold);
      chk("post_done_done", m_done, 1);
    end
    en1 = 1'b0;

    do_reset(0); run(0, 0, 1);
    do_reset(0); run(0, 1, 0);
    do_reset(1); run(1, 2, 0);

    // asynchronous reset in the middle of channel 1
    do_reset(0); mode = 0; en1 = 1'b1;
    repeat (22) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_zero("async_reset");
    en1 = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("after_reset_wr_en", m_wr_en, 0);
    end
    run(0, 0, 0);

    for (int it = 0; it < 4; it++) begin
      logic s;
      for (int i = 0; i < 32; i++) rnd[i] = int'($urandom_range(0, 65535)) - 32768;
      s = 1'($urandom_range(0, 1));
      do_reset(s);
      run(s, 3, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/maxpool_controller.md
Name: maxpool_controller

Overview:
- Counterpart of the upsampling address controller: downsamples a feature map stored channel-major/row-major in on-chip memory with STRIDE x STRIDE max pooling.
- Walks every pooling window, issues one source read address per cycle and takes the returned words after a fixed memory latency.
- Tracks the running maximum and issues one destination write (address, data, strobe) per window.
- Sits between the feature-map RAM read port and the RAM write port of the layer scheduler.

Parameters:
- WIDTH_SRC, 24, source map width; must be a multiple of STRIDE.
- HEIGHT_SRC, 24, source map height; must be a multiple of STRIDE.
- DEPTH_SRC, 128, channel count.
- STRIDE, 2, pooling window edge and step (window = STRIDE*STRIDE reads).
- DATA_W, 16, signed two's-complement data width.
- RD_LATENCY, 1, cycles from src_addr presented to rd_data valid (≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  permits issuing new reads; stalls issue when low.
- done  out  1  high once every output word has been written; sticky until reset.
- src_addr  out  `ADDR_SZ  source read address, registered.
- rd_data  in  DATA_W  memory read data, valid RD_LATENCY cycles after its address.
- des_addr  out  `ADDR_SZ  destination write address, registered.
- wr_data  out  DATA_W  pooled value, registered.
- wr_en  out  1  one-cycle write strobe qualifying des_addr/wr_data.

Behaviour:
- Reset: asynchronous, active-low. src_addr, des_addr, wr_data = 0; wr_en = 0; done = 0; all counters, pipeline valids and the accumulator are cleared. Reset mid-operation aborts in-flight reads with no write.
- Iteration order, outer to inner: channel c, out row r (0..HEIGHT_SRC/STRIDE-1), out col k (0..WIDTH_SRC/STRIDE-1), dy, dx (0..STRIDE-1).
- Address formulas, in the exact integer arithmetic of the `ADDR_SZ addresses:
  - src_addr = (k*STRIDE+dx) + WIDTH_SRC*((r*STRIDE+dy) + HEIGHT_SRC*c)
  - des_addr = k + (WIDTH_SRC/STRIDE)*(r + (HEIGHT_SRC/STRIDE)*c)
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: enters ISSUE on the first cycle enable=1.
  - ISSUE: each cycle with enable=1, registers the next src_addr, pushes a valid token (with a first-of-window and a last-of-window flag) into an RD_LATENCY-deep shift register, and advances the counters. With enable=0, no address advance and a zero token (stall). After the last address of the last window, goes to DRAIN.
  - DRAIN: waits until the shift register is empty and the final write has been issued, then goes to DONE.
  - DONE: done=1; holds until reset; enable is ignored.
- Token arrival (token exits the shift register, rd_data sampled):
  - first-of-window: acc = rd_data.
  - otherwise: acc = max(acc, rd_data), signed compare.
- Write timing: on the arrival of a last-of-window token, the next cycle drives wr_en=1, wr_data = final max and des_addr of that window. Write latency from the window's last src_addr = RD_LATENCY+1 cycles.
- Windows may straddle stalls. Data already in flight always completes regardless of enable.
- Back-to-back windows: the first-of-window token overwrites acc in the same cycle the previous window's result is registered, with no bubble. Throughput is 1 read/cycle and 1 write per STRIDE² cycles.
- Wrap: dx→dy→k→r→c counters wrap to 0 on reaching their limits. The c wrap at DEPTH_SRC ends ISSUE.
- Total writes = DEPTH_SRC*(HEIGHT_SRC/STRIDE)*(WIDTH_SRC/STRIDE). done rises the cycle after the last wr_en.

Optional Feature:
- MAXPOOL_RELU_EN defined: wr_data = (max < 0) ? 0 : max. This fuses ReLU into pooling, with no extra latency.
- Undefined: wr_data = raw signed max.

Decomposition:
- `ADDR_SZ stays in parameters.h.
- The shared package holds the FSM state encoding constants (IDLE/ISSUE/DRAIN/DONE) and DATA_W default.
- Natural sub-module: maxpool_addr_gen, containing the nested counters plus the src_addr/des_addr arithmetic and first/last flags. The top holds the FSM, latency shift register, accumulator and write stage.

Test Plan:
- W=4,H=4,D=2,S=2,RD_LATENCY=1, mem[a]=a, enable held high:
  - first src_addr sequence 0,1,4,5.
  - first wr_en 2 cycles after src_addr=5, with des_addr=0, wr_data=5.
  - 8 writes total, last is des_addr=7, wr_data=31.
  - done rises the cycle after.
- Same setup, enable toggled 1/0 every cycle:
  - identical write address/data sequence.
  - no duplicate or skipped src_addr.
  - done only after the 8th write.
- mem[a]=-(a+1), first window:
  - with MAXPOOL_RELU_EN undefined, wr_data=-1 (0xFFFF).
  - with it defined, wr_data=0.
- RD_LATENCY=3, mem[a]=a xor 3 (window 0 reads 3,2,7,6): first write wr_data=7, des_addr=0, 4 cycles after src_addr=5.
- reset_n pulsed low mid-channel 1:
  - all outputs 0 immediately (asynchronous).
  - no wr_en during or after reset until enable.
  - rerun produces the full 8-write sequence from src_addr=0.
- After done: enable held high for 20 cycles → no wr_en, src_addr stable, done stays 1.
